tmc4671_spi_scheduler: RTL
==========================

// Module: tmc4671_spi_scheduler
// PURPOSE
//  Sequences and shares the single TMC4671 SPI transaction core between two requesters:
//  a host port (one register read/write per request) and an autonomous poll engine.
//  The poll engine sweeps a table of NUM_POLL register addresses at POLL_FREQ_HZ and
//  keeps a shadow copy of each result. Sits between the Avalon glue and the SPI core.
//  Drives the core's transmit/addr/write/data inputs; owns the core's busy/data_out.
// PARAMETERS
//  CLOCK_FREQ_HZ   50_000_000  system clock frequency
//  POLL_FREQ_HZ    10_000      sweep start rate; PERIOD = CLOCK_FREQ_HZ/POLL_FREQ_HZ cycles
//  NUM_POLL        4           poll table entries (1..8)
//  TIMEOUT_CYCLES  2500        max cycles from spi_transmit to busy falling edge (50us)
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  reset_n       in   1          asynchronous, active-low reset
//  host_req      in   1          level; host transaction requested, held until host_ack
//  host_write    in   1          1 = write host_wdata to host_addr, 0 = read
//  host_addr     in   7          TMC4671 register address
//  host_wdata    in   32         write data
//  host_ack      out  1          1-cycle pulse: host transaction finished
//  host_rdata    out  32         read data, valid in host_ack cycle (0 for writes/timeout)
//  host_timeout  out  1          valid with host_ack: transaction aborted by timeout
//  poll_enable   in   1          1 = periodic sweeps run
//  poll_addr     in   7*NUM_POLL entry i at [7i+6:7i]; sampled at sweep start
//  poll_data     out  32*NUM_POLL shadow of entry i, updated when its read completes
//  poll_valid    out  NUM_POLL   bit i = poll_data[i] holds a good read
//  sweep_done    out  1          1-cycle pulse after last entry of a sweep completes
//  sweep_overrun out  1          1-cycle pulse: period tick while sweep still active
//  spi_transmit  out  1          1-cycle start pulse to SPI core
//  spi_addr      out  7          core address, stable from transmit until completion
//  spi_write     out  1          core write-not-read, stable as spi_addr
//  spi_wdata     out  32         core write data, stable as spi_addr
//  spi_rdata     in   32         core read data, valid at busy falling edge
//  spi_busy      in   1          core busy
// BEHAVIOUR
//  - Reset: all outputs 0, poll_valid 0, period counter 0, FSM IDLE, sweep inactive.
//    reset_n low mid-transaction forces spi_transmit 0 immediately; no ack issued.
//  - Period counter counts 0..PERIOD-1 continuously; tick at PERIOD-1. Tick with
//    poll_enable=1 and sweep inactive: latch poll_addr, sweep active, index=0. Tick while
//    sweep active: sweep_overrun pulse, tick dropped. poll_enable=0: no new sweeps,
//    active sweep runs to completion.
//  - FSM: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
//    IDLE: pick requester (arbitration below), register addr/write/wdata -> ISSUE.
//    ISSUE: spi_transmit=1 one cycle, start timeout counter -> WAIT_BUSY.
//    WAIT_BUSY: spi_busy=1 -> WAIT_DONE.  WAIT_DONE: spi_busy 1->0 -> complete, IDLE.
//    Timeout counter expiry (TIMEOUT_CYCLES after ISSUE) in WAIT_BUSY/WAIT_DONE -> abort, IDLE.
//  - Arbitration in IDLE, one transaction per grant, round-robin: if both host_req and
//    sweep pending, grant whichever was NOT granted last; single requester granted
//    directly. last_grant resets to poll (host wins first tie).
//  - Host completion: host_ack pulse in cycle after busy falling edge (registered);
//    host_rdata=spi_rdata for reads, 0 for writes. Timeout: host_ack=1, host_timeout=1,
//    host_rdata=0. host_req still high the cycle after host_ack = new request.
//  - Poll completion: poll_data[index]<=spi_rdata, poll_valid[index]<=1; timeout clears
//    poll_valid[index], data kept. index increments; after index NUM_POLL-1: sweep_done
//    pulse, sweep inactive. Poll transactions are always reads (spi_write=0, wdata=0).
//  - Back-to-back: min one IDLE cycle between transactions; no transmit while spi_busy=1.
// TESTING
//  - Host read addr 0x01, core model returns 0x00ABCDEF -> one spi_transmit, addr=0x01,
//    write=0; host_ack 1 cycle after busy falls, host_rdata=0x00ABCDEF, host_timeout=0.
//  - NUM_POLL=4, addrs 0x6A,0x6B,0x6C,0x6D, enable -> 4 reads in order, poll_valid=4'hF,
//    one sweep_done per PERIOD, each poll_data[i] matches model value.
//  - host_req held high during active sweep -> transactions alternate host,poll,host,poll;
//    host never waits more than one poll transaction.
//  - Core model never asserts busy -> after 2500 cycles host_ack=1, host_timeout=1,
//    host_rdata=0; for a poll entry poll_valid[i] drops to 0, sweep continues.
//  - Slow core (sweep > PERIOD) -> sweep_overrun pulses on every tick during sweep,
//    no second sweep starts until sweep_done.
//  - reset_n low in WAIT_DONE -> outputs 0 asynchronously, poll_valid=0; after release
//    first host request is served normally.

Source files
------------

// File: rtl/tmc4671_spi_scheduler.sv
// ============================================================================
// Module   : tmc4671_spi_scheduler
// Brief    : Shares one TMC4671 SPI transaction core between a host port and a
//            periodic register-poll engine that keeps a shadow of each result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tmc4671_spi_scheduler #(
   parameter int CLOCK_FREQ_HZ  = 50_000_000,
   parameter int POLL_FREQ_HZ   = 10_000,
   parameter int NUM_POLL       = 4,
   parameter int TIMEOUT_CYCLES = 2500
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     host_req,
   input  logic                     host_write,
   input  logic [6:0]               host_addr,
   input  logic [31:0]              host_wdata,
   output logic                     host_ack,
   output logic [31:0]              host_rdata,
   output logic                     host_timeout,
   input  logic                     poll_enable,
   input  logic [7*NUM_POLL-1:0]    poll_addr,
   output logic [32*NUM_POLL-1:0]   poll_data,
   output logic [NUM_POLL-1:0]      poll_valid,
   output logic                     sweep_done,
   output logic                     sweep_overrun,
   output logic                     spi_transmit,
   output logic [6:0]               spi_addr,
   output logic                     spi_write,
   output logic [31:0]              spi_wdata,
   input  logic [31:0]              spi_rdata,
   input  logic                     spi_busy
);

   localparam int PERIOD = CLOCK_FREQ_HZ / POLL_FREQ_HZ;
   localparam int PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int IDX_W  = (NUM_POLL > 1) ? $clog2(NUM_POLL) : 1;

   localparam logic [PCNT_W-1:0] c_period_last = PCNT_W'(PERIOD - 1);
   localparam logic [TMO_W-1:0]  c_tmo_last    = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [IDX_W-1:0]  c_idx_last    = IDX_W'(NUM_POLL - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t              r_state;
   logic [PCNT_W-1:0]   r_pcnt;
   logic [TMO_W-1:0]    r_tmo_cnt;
   logic                r_sweep_active;
   logic [IDX_W-1:0]    r_index;
   logic [7*NUM_POLL-1:0] r_tbl_addr;
   logic                r_cur_host;
   logic                r_last_host;
   logic [31:0]         r_poll_data [NUM_POLL];
   logic [NUM_POLL-1:0] r_poll_valid;

   logic [6:0]          w_tbl [NUM_POLL];
   logic                w_tick;
   logic                w_host_pend;
   logic                w_grant_host;
   logic                w_waiting;
   logic                w_done_ok;
   logic                w_expired;
   logic                w_fin;

   generate
      for (genvar gi = 0; gi < NUM_POLL; gi++) begin : g_entry
         assign w_tbl[gi]                = r_tbl_addr[7*gi +: 7];
         assign poll_data[32*gi +: 32]   = r_poll_data[gi];
      end
   endgenerate

   assign poll_valid = r_poll_valid;

   // host_req is still asserted during its own ack cycle; that is not a new request
   assign w_tick       = (r_pcnt == c_period_last);
   assign w_host_pend  = host_req && !host_ack;
   assign w_grant_host = w_host_pend && (!r_sweep_active || !r_last_host);
   assign w_waiting    = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
   assign w_done_ok    = (r_state == ST_WAIT_DONE) && !spi_busy;
   assign w_expired    = w_waiting && !w_done_ok && (r_tmo_cnt == c_tmo_last);
   assign w_fin        = w_done_ok || w_expired;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pcnt <= '0;
      end else if (w_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + PCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_tmo_cnt      <= '0;
         r_sweep_active <= 1'b0;
         r_index        <= '0;
         r_tbl_addr     <= '0;
         r_cur_host     <= 1'b0;
         r_last_host    <= 1'b0;
         r_poll_valid   <= '0;
         for (int i = 0; i < NUM_POLL; i++) r_poll_data[i] <= '0;
         host_ack       <= 1'b0;
         host_rdata     <= '0;
         host_timeout   <= 1'b0;
         sweep_done     <= 1'b0;
         sweep_overrun  <= 1'b0;
         spi_transmit   <= 1'b0;
         spi_addr       <= '0;
         spi_write      <= 1'b0;
         spi_wdata      <= '0;
      end else begin
         spi_transmit  <= 1'b0;
         host_ack      <= 1'b0;
         host_timeout  <= 1'b0;
         sweep_done    <= 1'b0;
         sweep_overrun <= 1'b0;

         if (w_tick) begin
            if (r_sweep_active) begin
               sweep_overrun <= 1'b1;
            end else if (poll_enable) begin
               r_tbl_addr     <= poll_addr;
               r_sweep_active <= 1'b1;
               r_index        <= '0;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (!spi_busy) begin
                  if (w_grant_host) begin
                     spi_addr     <= host_addr;
                     spi_write    <= host_write;
                     spi_wdata    <= host_wdata;
                     r_cur_host   <= 1'b1;
                     r_last_host  <= 1'b1;
                     spi_transmit <= 1'b1;
                     r_state      <= ST_ISSUE;
                  end else if (r_sweep_active) begin
                     spi_addr     <= w_tbl[r_index];
                     spi_write    <= 1'b0;
                     spi_wdata    <= '0;
                     r_cur_host   <= 1'b0;
                     r_last_host  <= 1'b0;
                     spi_transmit <= 1'b1;
                     r_state      <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               r_tmo_cnt <= TMO_W'(1);
               r_state   <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
               if (spi_busy) r_state <= ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
               r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end
            default: r_state <= ST_IDLE;
         endcase

         // Completion or abort; overrides the WAIT_BUSY advance above
         if (w_fin) begin
            r_state <= ST_IDLE;
            if (r_cur_host) begin
               host_ack     <= 1'b1;
               host_timeout <= w_expired;
               host_rdata   <= (w_done_ok && !spi_write) ? spi_rdata : 32'h0;
            end else begin
               for (int i = 0; i < NUM_POLL; i++) begin
                  if (r_index == IDX_W'(i)) begin
                     if (w_done_ok) begin
                        r_poll_data[i]  <= spi_rdata;
                        r_poll_valid[i] <= 1'b1;
                     end else begin
                        r_poll_valid[i] <= 1'b0;
                     end
                  end
               end
               if (r_index == c_idx_last) begin
                  r_sweep_active <= 1'b0;
                  r_index        <= '0;
                  sweep_done     <= 1'b1;
               end else begin
                  r_index <= r_index + IDX_W'(1);
               end
            end
         end
      end
   end

endmodule

`default_nettype wire
